aes_round: RTL and testbench

- One unrolled AES-128 encryption round plus the matching key-schedule step, with registered outputs.
- Ten instances are chained in the unrolled encryption datapath, with curRnd = 1..10.
- Each instance takes the state after the previous AddRoundKey and the previous round key.
- Each instance produces the next round key and the state after this round's AddRoundKey.

---
 rtl/aes_round.sv | 128 ++++++++++++
 tb/tb_aes_round.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_round.sv
// One unrolled AES-128 round with its key-schedule step, registered on both outputs.
// Define AES_LAST_ROUND_EN to bypass MixColumns when curRnd == 10 (standard final round).
module aes_round (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   curRnd,
  input  logic [0:127] prevRK,
  input  logic [0:127] rndDataIn,
  output logic [0:127] curRK,
  output logic [0:127] rndDataOut
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   key_b   [16];
  logic [7:0]   din_b   [16];
  logic [7:0]   sub_b   [16];
  logic [7:0]   shift_b [16];
  logic [7:0]   mix_b   [16];
  logic [7:0]   nk_b    [16];
  logic [7:0]   rcon;
  logic         last_round;
  logic [0:127] cur_rk_d, cur_rk_q;
  logic [0:127] rnd_data_out_d, rnd_data_out_q;

  // Byte i occupies row i%4, column i/4 of the state.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      assign key_b[gi]   = prevRK[8*gi +: 8];
      assign din_b[gi]   = rndDataIn[8*gi +: 8];
      assign sub_b[gi]   = SBOX[din_b[gi]];
      assign shift_b[gi] = sub_b[ROW + 4*((COL + ROW) % 4)];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = shift_b[4*gi];
      assign a1 = shift_b[4*gi+1];
      assign a2 = shift_b[4*gi+2];
      assign a3 = shift_b[4*gi+3];
      assign mix_b[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mix_b[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mix_b[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mix_b[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

`ifdef AES_LAST_ROUND_EN
  assign last_round = (curRnd == 4'd10);
`else
  assign last_round = 1'b0;
`endif

  always_comb begin
    rcon = 8'h00;
    case (curRnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // t = SubWord(RotWord(w3)) ^ Rcon, then each new word chains off the previous one.
  always_comb begin
    for (int b = 0; b < 16; b++) nk_b[b] = 8'h00;
    for (int b = 0; b < 4; b++) begin
      nk_b[b]      = key_b[b] ^ SBOX[key_b[12 + ((b + 1) % 4)]] ^ ((b == 0) ? rcon : 8'h00);
      nk_b[4 + b]  = key_b[4 + b]  ^ nk_b[b];
      nk_b[8 + b]  = key_b[8 + b]  ^ nk_b[4 + b];
      nk_b[12 + b] = key_b[12 + b] ^ nk_b[8 + b];
    end
  end

  always_comb begin
    cur_rk_d       = '0;
    rnd_data_out_d = '0;
    for (int i = 0; i < 16; i++) begin
      cur_rk_d[8*i +: 8]       = nk_b[i];
      rnd_data_out_d[8*i +: 8] = (last_round ? shift_b[i] : mix_b[i]) ^ nk_b[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_rk_q       <= '0;
      rnd_data_out_q <= '0;
    end else begin
      cur_rk_q       <= cur_rk_d;
      rnd_data_out_q <= rnd_data_out_d;
    end
  end

  assign curRK      = cur_rk_q;
  assign rndDataOut = rnd_data_out_q;

endmodule

// File: tb/tb_aes_round.sv
// Self-checking bench for aes_round: directed FIPS-197 vectors plus randomized
// traffic against a GF(2^8) reference model built from first principles.
module tb_aes_round;

  logic         clk;
  logic         rst;
  logic [3:0]   curRnd;
  logic [0:127] prevRK;
  logic [0:127] rndDataIn;
  logic [0:127] curRK;
  logic [0:127] rndDataOut;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  logic [7:0] sbox_tb [256];

  aes_round dut (
    .clk        (clk),
    .rst        (rst),
    .curRnd     (curRnd),
    .prevRK     (prevRK),
    .rndDataIn  (rndDataIn),
    .curRK      (curRK),
    .rndDataOut (rndDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] xx;
    xx = {x, x} << n;
    return xx[15:8];
  endfunction

  // S-box = multiplicative inverse followed by the AES affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] model_rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    if (rnd == 4'd0 || rnd > 4'd10) return 8'h00;
    rc = 8'h01;
    for (int i = 1; i < int'(rnd); i++) rc = gmul(rc, 8'h02);
    return rc;
  endfunction

  function automatic logic [0:127] model_key(input logic [3:0] rnd, input logic [0:127] k);
    logic [7:0]   w [4][4];
    logic [7:0]   t [4];
    logic [0:127] r;
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 4; b++) w[j][b] = k[32*j + 8*b +: 8];
    for (int b = 0; b < 4; b++) t[b] = sbox_tb[w[3][(b + 1) % 4]];
    t[0] = t[0] ^ model_rcon(rnd);
    for (int b = 0; b < 4; b++) w[0][b] = w[0][b] ^ t[b];
    for (int j = 1; j < 4; j++)
      for (int b = 0; b < 4; b++) w[j][b] = w[j][b] ^ w[j-1][b];
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 4; b++) r[32*j + 8*b +: 8] = w[j][b];
    return r;
  endfunction

  function automatic logic [0:127] model_data(input logic [3:0] rnd, input logic [0:127] k,
                                              input logic [0:127] d);
    logic [0:127] nk;
    logic [0:127] r;
    logic [7:0]   sb [4][4];
    logic [7:0]   sh [4][4];
    logic [7:0]   mx [4][4];
    logic [7:0]   coef [4];
    bit           mix;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
`ifdef AES_LAST_ROUND_EN
    mix = (rnd != 4'd10);
`else
    mix = 1'b1;
`endif
    nk = model_key(rnd, k);
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) sb[row][c] = sbox_tb[d[8*(row + 4*c) +: 8]];
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) sh[row][c] = sb[row][(c + row) % 4];
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) begin
        mx[row][c] = 8'h00;
        for (int j = 0; j < 4; j++) mx[row][c] = mx[row][c] ^ gmul(coef[(j - row + 4) % 4], sh[j][c]);
        if (!mix) mx[row][c] = sh[row][c];
        r[8*(row + 4*c) +: 8] = mx[row][c] ^ nk[8*(row + 4*c) +: 8];
      end
    return r;
  endfunction

  task automatic check_vec(input string tag, input logic [0:127] got, input logic [0:127] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_cycle(input logic r, input logic [3:0] rn, input logic [0:127] k,
                           input logic [0:127] d, input logic [0:127] exp_k,
                           input logic [0:127] exp_d, input string tag);
    rst       = r;
    curRnd    = rn;
    prevRK    = k;
    rndDataIn = d;
    @(posedge clk);
    #1;
    check_vec({tag, "_rk"}, curRK, exp_k);
    check_vec({tag, "_out"}, rndDataOut, exp_d);
    n_txn++;
    $display("txn %0d %s rst=%0b rnd=%0d rk=%h out=%h", n_txn, tag, r, rn, curRK, rndDataOut);
  endtask

  task automatic model_cycle(input logic r, input logic [3:0] rn, input logic [0:127] k,
                             input logic [0:127] d, input string tag);
    logic [0:127] ek, ed;
    ek = r ? model_key(rn, k) : '0;
    ed = r ? model_data(rn, k, d) : '0;
    run_cycle(r, rn, k, d, ek, ed, tag);
  endtask

  localparam logic [0:127] K0 = 128'h5468617473206D79204B756E67204675;
  localparam logic [0:127] D0 = 128'h001F0E543C4E08596E221B0B4774311A;
  localparam logic [0:127] K1 = 128'hE232FCF191129188B159E4E6D679A293;
  localparam logic [0:127] D1 = 128'h5847088B15B61CBA59D4E2E8CD39DFCE;
  localparam logic [0:127] K2 = 128'h56082007C71AB18F76435569A03AF7FA;
  localparam logic [0:127] D2 = 128'h43C6A9620E57C0C80908EBFE3DF87F37;
  localparam logic [0:127] K9 = 128'hAC7766F319FADC2128D12941575C006E;
  localparam logic [0:127] D9 = 128'hEB598B1B402EA1C3F23813421E84E7D2;
  localparam logic [0:127] KA = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;
  localparam logic [0:127] DA = 128'h3925841D02DC09FBDC118597196A0B32;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [0:127] rk, rd, exp_final;
    logic         rr;
    logic [3:0]   rn;
    rst       = 1'b0;
    curRnd    = 4'd0;
    prevRK    = '0;
    rndDataIn = '0;
    build_sbox();

    for (int i = 0; i < 3; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_cycle(1'b0, 4'($urandom_range(0, 15)), rk, rd, '0, '0, "reset");
    end

    run_cycle(1'b1, 4'd1, K0, D0, K1, D1, "round1");
    run_cycle(1'b1, 4'd2, K1, D1, K2, D2, "round2");

`ifdef AES_LAST_ROUND_EN
    exp_final = DA;
`else
    exp_final = model_data(4'd10, K9, D9);
`endif
    run_cycle(1'b1, 4'd10, K9, D9, KA, exp_final, "final");

    // Back-to-back alternation with a one-cycle reset in the middle.
    for (int i = 0; i < 8; i++) begin
      rr = (i != 4);
      if (i % 2 == 0)
        run_cycle(rr, 4'd1, K0, D0, rr ? K1 : '0, rr ? D1 : '0, "b2b_r1");
      else
        run_cycle(rr, 4'd2, K1, D1, rr ? K2 : '0, rr ? D2 : '0, "b2b_r2");
    end

    for (int i = 0; i < 200; i++) begin
      rr = ($urandom_range(0, 15) != 0);
      rn = 4'($urandom_range(0, 15));
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_cycle(rr, rn, rk, rd, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
